pp_accum: RTL and testbench
===========================

# pp_accum

Sequential accumulator directly downstream of the radix-8 partial-product generator. It accepts one 17-bit partial product per handshake, together with that product's one's-complement negate flag. Each term is sign-corrected and weighted by 8^k, and NPP terms are summed into a 32-bit product. It turns the per-window generator into a compact sequential 16x16 multiplier datapath. It also exports the index of the window it expects next, so the upstream sequencer can steer the generator's window select.

## Interface
- PP_W, 17, partial-product width
- NPP, 6, partial products per multiplication (radix-8 windows for a 16-bit multiplier)
- SHIFT, 3, weight step in bits between consecutive partial products
- OUT_W, 32, product width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a new accumulation; honoured only in IDLE
- pp_valid  in  1  pp/pp_neg valid this cycle
- pp  in  PP_W  partial-product word
- pp_neg  in  1  1 = pp is the one's complement of the magnitude
- pp_ready  out  1  accumulator accepts a term this cycle
- pp_idx  out  3  index k (0..NPP-1) of the next term to be accepted
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse, product updated this cycle
- product  out  OUT_W  last completed product, held until next completion

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE -> ACCUM on start=1; acc cleared to 0 and pp_idx cleared to 0 on that edge.
- ACCUM: pp_ready=1. On pp_valid&pp_ready:
  - term value v = {sign-extend pp_neg above pp} + pp_neg.
  - Negative case: v = -(~pp).
  - acc <= acc + (v << (SHIFT*pp_idx)), all modulo 2^OUT_W.
  - pp_idx increments.
- No handshake while pp_valid=0: state, acc and pp_idx hold (bubbles allowed).
- Accepting term NPP-1 -> DONE. product <= final acc sum, including that term.
- DONE lasts exactly one cycle: done=1, busy=0, pp_ready=0; then -> IDLE.
- Ignored inputs:
  - start in ACCUM or DONE has no effect.
  - pp_valid outside ACCUM has no effect.
- Reset values: state IDLE, acc 0, pp_idx 0, product 0, pp_ready 0, busy 0, done 0.
- Reset asserted mid-ACCUM aborts the operation. No done is produced and product returns to 0.
- Arithmetic width: v is PP_W+1 bits signed; shifted term and acc are OUT_W bits. Bits above OUT_W are discarded.

## Timing
- pp_ready, busy and done are registered state decodes: no combinational path from inputs.
- start sampled at edge 0 -> ACCUM, pp_ready=1, busy=1 in cycle 1.
- With pp_valid held high, terms k=0..5 are accepted in cycles 1..6.
- done=1 and product valid in cycle 7; IDLE in cycle 8. Start-to-done minimum = NPP+1 cycles.
- Each bubble cycle adds one cycle of latency.
- start asserted in the DONE cycle is ignored. Earliest restart is start sampled in cycle 8.
- pp_idx is valid in every cycle and equals the number of terms accepted so far in this operation.

## Test plan
- Unweighted ones: start; six terms pp=17'h00001, pp_neg=0, back-to-back -> done in cycle 7, product = 32'd37449 (sum of 8^k, k=0..5), pp_idx steps 0..5.
- Negation: term0 pp=17'h1FFFE, pp_neg=1 (-1); terms 1..5 pp=0, neg=0 -> product = 32'hFFFFFFFF.
- Top weight/truncation: terms 0..4 zero; term5 pp=17'h1FFFF, neg=0 -> product = 32'hFFFF8000.
- Bubbles: ones pattern with pp_valid toggling 1,0,1,0… -> product 32'd37449, done 12 cycles after start, no term lost or duplicated.
- Start while busy: assert start at cycles 3 and 7 of a running op -> ignored, single done, result unchanged.
- Reset mid-op: after 3 accepted terms, pulse rst_n low asynchronously -> busy, pp_ready, product, pp_idx all 0 immediately. A following full op yields the correct product.

Source files
------------

// File: rtl/pp_accum_if.sv
// Handshake bundle between the partial-product sequencer and pp_accum.
// master = upstream sequencer side, slave = accumulator side.
interface pp_accum_if #(
   parameter int PP_W  = 17,
   parameter int OUT_W = 32,
   parameter int IDX_W = 3
);
   logic             start;
   logic             pp_valid;
   logic [PP_W-1:0]  pp;
   logic             pp_neg;
   logic             pp_ready;
   logic [IDX_W-1:0] pp_idx;
   logic             busy;
   logic             done;
   logic [OUT_W-1:0] product;

   modport master (
      output start, pp_valid, pp, pp_neg,
      input  pp_ready, pp_idx, busy, done, product
   );

   modport slave (
      input  start, pp_valid, pp, pp_neg,
      output pp_ready, pp_idx, busy, done, product
   );
endinterface

// File: rtl/pp_accum.sv
// Sequential accumulator for radix-8 partial products: sign-corrects each
// one's-complement term, weights it by 8^k and sums NPP terms into a product.
module pp_accum #(
   parameter int PP_W  = 17,
   parameter int NPP   = 6,
   parameter int SHIFT = 3,
   parameter int OUT_W = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   pp_accum_if.slave   bus
);
   localparam int IDX_W = 3;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_q,   state_d;
   logic [OUT_W-1:0] acc_q,     acc_d;
   logic [OUT_W-1:0] product_q, product_d;
   logic [IDX_W-1:0] idx_q,     idx_d;

   logic [PP_W:0]    term_v;
   logic [OUT_W-1:0] term_ext;
   logic [OUT_W-1:0] term_sh;
   logic [OUT_W-1:0] acc_sum;
   logic [5:0]       shamt;

   // Term datapath: one's complement correction (+neg), sign extension to
   // product width, then weight 8^k via shift; overflow bits are dropped.
   always_comb begin
      term_v   = {bus.pp_neg, bus.pp} + {{PP_W{1'b0}}, bus.pp_neg};
      term_ext = {{(OUT_W-PP_W-1){term_v[PP_W]}}, term_v};
      shamt    = 6'(SHIFT * idx_q);
      term_sh  = term_ext << shamt;
      acc_sum  = acc_q + term_sh;
   end

   // Control FSM: start only honoured in IDLE, terms only taken in ACCUM,
   // DONE is a single-cycle state that publishes the product.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      product_d = product_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_ACCUM;
               acc_d   = '0;
               idx_d   = '0;
            end
         end
         S_ACCUM: begin
            if (bus.pp_valid) begin
               acc_d = acc_sum;
               idx_d = idx_q + 1'b1;
               if (idx_q == IDX_W'(NPP-1)) begin
                  state_d   = S_DONE;
                  product_d = acc_sum;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         idx_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         idx_q     <= idx_d;
         product_q <= product_d;
      end
   end

   // Status outputs are pure decodes of registered state.
   always_comb begin
      bus.pp_ready = (state_q == S_ACCUM);
      bus.busy     = (state_q == S_ACCUM);
      bus.done     = (state_q == S_DONE);
      bus.pp_idx   = idx_q;
      bus.product  = product_q;
   end
endmodule

// File: tb/tb_pp_accum.sv
// Self-checking bench for pp_accum: directed cases plus randomized terms
// against an arithmetic reference (sum of signed terms times 8^k).
module tb_pp_accum;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [16:0] tpp  [6];
   bit          tneg [6];

   pp_accum_if bus ();

   pp_accum dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: each term is +pp, or -(~pp) when negated, weighted by 8^k.
   function automatic logic [31:0] model();
      longint      s = 0;
      for (int k = 0; k < 6; k++) begin
         logic [16:0] c;
         longint      v;
         c = ~tpp[k];
         v = tneg[k] ? -longint'(c) : longint'(tpp[k]);
         s += v * (longint'(1) << (3*k));
      end
      return s[31:0];
   endfunction

   // One operation. vmode: 0 back-to-back, 1 alternate valid, 2 random valid.
   task automatic do_op(input string tag, input int vmode, input bit spam, input int exp_lat);
      int          cyc = 1;
      int          k   = 0;
      logic [31:0] exp_p;
      exp_p = model();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      while (k < 6 && cyc < 200) begin
         check({tag, "_ready"}, bus.pp_ready, 1);
         check({tag, "_busy"},  bus.busy, 1);
         check({tag, "_idx"},   bus.pp_idx, k);
         check({tag, "_nodone"}, bus.done, 0);
         case (vmode)
            0:       bus.pp_valid = 1'b1;
            1:       bus.pp_valid = (cyc % 2 == 1);
            default: bus.pp_valid = 1'($urandom_range(0, 1));
         endcase
         bus.pp     = tpp[k];
         bus.pp_neg = tneg[k];
         bus.start  = spam && (cyc == 3);
         tick();
         if (bus.pp_valid) k++;
         cyc++;
      end
      bus.pp_valid = 1'b0;
      bus.start    = 1'b0;
      bus.pp       = 17'h15A5A;
      check({tag, "_done"},    bus.done, 1);
      check({tag, "_product"}, bus.product, exp_p);
      check({tag, "_dbusy"},   bus.busy, 0);
      check({tag, "_dready"},  bus.pp_ready, 0);
      if (exp_lat > 0) check({tag, "_lat"}, cyc, exp_lat);
      bus.start = spam;        // start in DONE must be ignored
      tick();
      bus.start = 1'b0;
      check({tag, "_done_once"}, bus.done, 0);
      check({tag, "_idle_busy"}, bus.busy, 0);
      check({tag, "_held"},      bus.product, exp_p);
      tick();
      check({tag, "_stay_idle"}, bus.busy, 0);
   endtask

   task automatic fill(input logic [16:0] p, input bit n);
      for (int k = 0; k < 6; k++) begin
         tpp[k]  = p;
         tneg[k] = n;
      end
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.pp_valid = 1'b0;
      bus.pp       = '0;
      bus.pp_neg   = 1'b0;
      #12;
      check("rst_product", bus.product, 0);
      check("rst_busy",    bus.busy, 0);
      check("rst_ready",   bus.pp_ready, 0);
      check("rst_done",    bus.done, 0);
      check("rst_idx",     bus.pp_idx, 0);
      rst_n = 1'b1;
      tick();

      // Valid terms while IDLE must be ignored.
      bus.pp_valid = 1'b1;
      bus.pp       = 17'h00001;
      tick();
      tick();
      bus.pp_valid = 1'b0;
      check("idle_valid_busy", bus.busy, 0);
      check("idle_valid_idx",  bus.pp_idx, 0);

      fill(17'h00001, 1'b0);
      do_op("ones", 0, 1'b0, 7);
      check("ones_const", bus.product, 32'd37449);

      fill(17'h00000, 1'b0);
      tpp[0] = 17'h1FFFE; tneg[0] = 1'b1;
      do_op("neg", 0, 1'b0, 7);
      check("neg_const", bus.product, 32'hFFFFFFFF);

      fill(17'h00000, 1'b0);
      tpp[5] = 17'h1FFFF;
      do_op("top", 0, 1'b0, 7);
      check("top_const", bus.product, 32'hFFFF8000);

      fill(17'h00001, 1'b0);
      do_op("bubble", 1, 1'b0, 12);
      check("bubble_const", bus.product, 32'd37449);

      for (int k = 0; k < 6; k++) begin
         tpp[k]  = 17'($urandom);
         tneg[k] = 1'($urandom);
      end
      do_op("spam", 0, 1'b1, 7);

      // Reset mid-operation after three accepted terms.
      bus.start = 1'b1;
      tick();
      bus.start    = 1'b0;
      bus.pp_valid = 1'b1;
      bus.pp       = 17'h00123;
      tick();
      tick();
      tick();
      bus.pp_valid = 1'b0;
      check("mid_idx", bus.pp_idx, 3);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy",    bus.busy, 0);
      check("arst_ready",   bus.pp_ready, 0);
      check("arst_product", bus.product, 0);
      check("arst_idx",     bus.pp_idx, 0);
      #3;
      rst_n = 1'b1;
      tick();
      check("arst_nodone", bus.done, 0);

      fill(17'h00001, 1'b0);
      do_op("post_rst", 0, 1'b0, 7);

      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 6; k++) begin
            tpp[k]  = 17'($urandom);
            tneg[k] = 1'($urandom);
         end
         do_op("rand", (r % 2 == 0) ? 0 : 2, 1'($urandom), (r % 2 == 0) ? 7 : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
